ram_mport_arb: RTL
==================

// Module: ram_mport_arb
// PURPOSE
//  Parametrised single-bank RAM shared by NPORTS requesters (fetch, load/store, debug/loader).
//  Round-robin arbiter grants one valid/ready request per cycle; writes take byte enables,
//  reads return on a shared tagged response bus with word and byte-lane data.
//  Successor to the fixed iram/dram select-mux: adds arbitration, handshakes and misaligned read splitting.
// PARAMETERS
//  XLEN    32    data width in bits; must be 32 (4 byte lanes)
//  DEPTH   2048  words; power of two
//  NPORTS  3     requesters, 2..8
// PORTS
//  clk_i          in   1             clock, single clock domain
//  rst_i          in   1             synchronous reset, active-high
//  req_valid_i    in   NPORTS        request valid, one bit per port
//  req_ready_o    out  NPORTS        grant; one-hot or zero; request transfers when valid&ready
//  req_we_i       in   NPORTS        1 = write, 0 = read
//  req_addr_i     in   NPORTS*XLEN   byte address, port p at [p*XLEN +: XLEN]
//  req_wdata_i    in   NPORTS*XLEN   write data, lane-absolute
//  req_be_i       in   NPORTS*4      write byte enables
//  rsp_valid_o    out  1             read data valid, 1-cycle pulse
//  rsp_id_o       out  $clog2(NPORTS) port that issued the read
//  rsp_data_o     out  XLEN          read word, shifted right by 8*offset when misaligned
//  rsp_byte_o     out  8             byte at the read's byte address
// BEHAVIOUR
//  - Reset: rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_byte_o=0, FSM=IDLE,
//    rr pointer=NPORTS-1 (port 0 highest priority first). req_ready_o=0 while rst_i=1.
//    RAM contents not reset. Reset mid-split drops the in-flight read; no response issued.
//  - Word index = addr[2 +: $clog2(DEPTH)]; upper bits ignored (wraps modulo DEPTH).
//  - Arbiter, IDLE only: req_ready_o combinational from req_valid_i; winner is first valid
//    port after rr pointer (circular). Pointer updates to the winner on every grant.
//    No grant in SPLIT.
//  - Write: at grant edge, lanes with be=1 of the word are written. addr[1:0] ignored.
//    No response. be=0 is a legal no-op and still consumes the grant.
//  - Aligned read: RAM read at grant edge; the next cycle drives rsp_valid_o=1 with
//    rsp_id_o=port and rsp_data_o=word. Latency 1.
//  - Read-after-write: a read granted the cycle after a write to the same word returns new data.
//  - rsp_byte_o = rsp_data_o[7:0] (the addressed byte after alignment shift).
//  - Back-to-back: a new request may be granted in the same cycle rsp_valid_o is high.
//    Peak rate is one aligned access per cycle.
//  - FSM: IDLE -> SPLIT on grant of a misaligned read; SPLIT -> IDLE unconditionally next cycle.
// CONFIGURATION
//  RAM_MISALIGN_EN defined: a read with addr[1:0]!=0 reads word W at grant, enters SPLIT,
//    then reads word (W+1) mod DEPTH. Next cycle: rsp_data_o = {word(W+1),word(W)} >> (8*addr[1:0]),
//    low XLEN bits. Latency 2, arbiter blocked for 1 cycle.
//  RAM_MISALIGN_EN undefined: addr[1:0] ignored for rsp_data_o (aligned word, latency 1, no SPLIT).
//    rsp_byte_o still selects lane addr[1:0] of the word.
// TESTING
//  1 Reset: rst_i=1 for 3 cycles with all ports valid -> req_ready_o=0, rsp_valid_o=0 throughout.
//  2 Write/read: port0 writes 0xDEADBEEF be=4'b1111 @0x10, then be=4'b0010 data 0x0000AA00;
//    read @0x10 -> rsp_valid_o=1 one cycle after grant, rsp_id_o=0, rsp_data_o=0xDEADAAEF.
//  3 Round robin: ports 0,1,2 hold reads continuously -> grants 0,1,2,0,1,2; each rsp_id_o
//    matches, one rsp per cycle, no bubbles.
//  4 Misaligned (RAM_MISALIGN_EN): word0=0x44332211, word1=0x88776655, read @0x1
//    -> rsp 2 cycles after grant, rsp_data_o=0x55443322, rsp_byte_o=0x22, no grant in SPLIT.
//    Without the macro: rsp_data_o=0x44332211, rsp_byte_o=0x22, latency 1.
//  5 Wrap: read byte addr 4*DEPTH+8 returns word 2.
//    Misaligned read of word DEPTH-1 @offset 3 merges word 0 into the top bytes.
//  6 Reset in SPLIT: assert rst_i in the cycle after a misaligned grant
//    -> no rsp_valid_o; first post-reset grant goes to port 0.

Source files
------------

// File: rtl/ram_mport_arb.sv
// rtl/ram_mport_arb.sv - round-robin multi-port RAM with tagged read responses
// Optional RAM_MISALIGN_EN: misaligned reads span two words (latency 2, arbiter blocked 1 cycle).
module ram_mport_arb #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2048,
  parameter int NPORTS = 3,
  localparam int IDW   = $clog2(NPORTS),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NPORTS-1:0]      req_valid_i,
  output logic [NPORTS-1:0]      req_ready_o,
  input  logic [NPORTS-1:0]      req_we_i,
  input  logic [NPORTS*XLEN-1:0] req_addr_i,
  input  logic [NPORTS*XLEN-1:0] req_wdata_i,
  input  logic [NPORTS*4-1:0]    req_be_i,
  output logic                   rsp_valid_o,
  output logic [IDW-1:0]         rsp_id_o,
  output logic [XLEN-1:0]        rsp_data_o,
  output logic [7:0]             rsp_byte_o
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   mem [DEPTH];
  logic [IDW-1:0]    rr_ptr, win, cand;
  logic              found, grant, split_go;
  logic              sel_we;
  logic [XLEN-1:0]   sel_addr, sel_wdata;
  logic [3:0]        sel_be;
  logic [AW-1:0]     idx, hi_idx;
  logic [1:0]        off, split_off, rsp_off;
  logic [IDW-1:0]    split_id;
  logic [XLEN-1:0]   lo_word, merged;
  logic [2*XLEN-1:0] cat;

  // First valid port strictly after the pointer, searching circularly.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NPORTS);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant       = found && (state == IDLE) && !rst_i;
  assign req_ready_o = grant ? (NPORTS'(1) << win) : '0;

  assign sel_we    = req_we_i[win];
  assign sel_addr  = req_addr_i[win*XLEN +: XLEN];
  assign sel_wdata = req_wdata_i[win*XLEN +: XLEN];
  assign sel_be    = req_be_i[win*4 +: 4];
  assign idx       = sel_addr[2 +: AW];
  assign off       = sel_addr[1:0];

`ifdef RAM_MISALIGN_EN
  assign split_go = grant && !sel_we && (off != 2'd0);
`else
  assign split_go = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (split_go) state_n = SPLIT;
      SPLIT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Storage and split bookkeeping carry no reset.
  always_ff @(posedge clk_i) begin
    if (grant && sel_we) begin
      for (int b = 0; b < 4; b++)
        if (sel_be[b]) mem[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
    end
    if (split_go) begin
      lo_word   <= mem[idx];
      hi_idx    <= idx + AW'(1);
      split_off <= off;
      split_id  <= win;
    end
  end

  assign cat    = {mem[hi_idx], lo_word};
  assign merged = XLEN'(cat >> {split_off, 3'b000});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_off     <= '0;
      rr_ptr      <= IDW'(NPORTS - 1);
    end else begin
      rsp_valid_o <= 1'b0;
      if (grant) rr_ptr <= win;
      if (state == SPLIT) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= split_id;
        rsp_data_o  <= merged;
        rsp_off     <= '0;
      end else if (grant && !sel_we && !split_go) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= win;
        rsp_data_o  <= mem[idx];
        rsp_off     <= off;
      end
    end
  end

  // Merged responses are already shifted, so their lane offset is recorded as 0.
  assign rsp_byte_o = rsp_data_o[8*rsp_off +: 8];

endmodule
